ram_scan_reader: RTL
====================

# ram_scan_reader

- Read-side sequencer for the 32x4 dual-port RAM.
- Drives the RAM read address and steps through all locations, either automatically on a prescaled tick or one location per step pulse.
- Absorbs the RAM's one-cycle read latency and presents a coherent, glitch-free address/data pair to the HEX display stage.
- Sits between the board inputs (run switch, debounced step key) and the RAM read port / display organizer; replaces a free-running read-address counter.

## Interface
Parameters:
- ADDR_W, 5, RAM address width; depth is 2**ADDR_W.
- DATA_W, 4, RAM word width.
- TICK_CYCLES, 50_000_000, clk cycles per auto-advance in run mode (≥1); benches override it to a small value.

Ports:
- clk  in  1  system clock, CLOCK_50 domain. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- run  in  1  level, already synchronized; 1 = auto-advance on tick, 0 = manual.
- step  in  1  single-cycle pulse, already edge-detected; advances one address when run=0.
- wr_en  in  1  RAM write enable, mirrored from the write path.
- wr_addr  in  ADDR_W  RAM write address, mirrored.
- rd_q  in  DATA_W  RAM q; valid the cycle after the RAM samples rd_addr.
- rd_addr  out  ADDR_W  to RAM rdaddress; registered.
- disp_addr  out  ADDR_W  address currently displayed.
- disp_data  out  DATA_W  data read from disp_addr.
- disp_valid  out  1  high once the first pair is captured after reset.
- wrap  out  1  one-cycle pulse when rd_addr advances from 2**ADDR_W-1 to 0.

## Operation
- FSM states:
  - ISSUE: rd_addr holds the target; the RAM samples it at the end of this cycle. Goes to CAPTURE unconditionally.
  - CAPTURE: rd_q is valid. At the end of the cycle: disp_addr←rd_addr, disp_data←rd_q, disp_valid←1. Goes to HOLD.
  - HOLD: waits for an advance event.
- Advance event (HOLD only):
  - run=1: the tick fires.
  - run=0: step=1.
  - On advance: rd_addr←rd_addr+1, mod 2**ADDR_W, with natural wrap; wrap←1 if the old value was max; go to ISSUE.
- Tick prescaler:
  - Counts only while state=HOLD and run=1; cleared in every other case.
  - Fires when the count reaches TICK_CYCLES-1, then clears.
- Ignored events:
  - step while run=1.
  - step in ISSUE/CAPTURE (not queued).
- disp_* hold their previous values through ISSUE/CAPTURE; they never show a mismatched pair.
- Reset values: rd_addr=0, disp_addr=0, disp_data=0, disp_valid=0, wrap=0, prescaler=0, state=ISSUE.
- Reset mid-operation discards any in-flight read.
- After reset, the first pair (address 0) is captured with no advance event.

## Timing
- Reset released at edge r: ISSUE during cycle r+1; disp_valid=1 and address-0 data visible after edge r+2.
- Advance seen at edge k: rd_addr=new value after edge k; new disp pair after edge k+2.
- Minimum period per address: 3 cycles (TICK_CYCLES=1, run=1).
- In run mode, address period = TICK_CYCLES+2 cycles.
- wrap is high exactly in the cycle after the advancing edge, aligned with the new rd_addr.

## Configuration
- Macro RAM_SCAN_WRITE_REFRESH_EN.
- Defined:
  - A 1-bit refresh_pending flag sets on any cycle with wr_en=1 and wr_addr==rd_addr.
  - In HOLD, if refresh_pending=1 and there is no advance event, go to ISSUE with rd_addr unchanged and clear the flag.
  - An advance clears the flag.
  - A write during ISSUE/CAPTURE therefore forces a re-read, avoiding old-data capture on same-address collisions.
  - Re-read latency: new data is displayed 3 edges after the write edge, from HOLD.
- Undefined:
  - wr_en and wr_addr are present but ignored.
  - Displayed data can be stale until the next time the address is revisited.

## Structure
- Package ram_scan_pkg holds:
  - the state enum, scan_state_t {ISSUE, CAPTURE, HOLD};
  - default constants RAM_ADDR_W=5 and RAM_DATA_W=4, shared with the write path and display organizer.
- One sub-module: tick_gen (parameter TICK_CYCLES; inputs clk, reset, en; output tick), wrapping the prescaler.

## Test plan
- Reset, run=0, RAM preloaded with MIF value 0xA at address 0 → disp_valid=0 then 1 two edges after release, disp_addr=0, disp_data=0xA, and no further change with step=0.
- run=0, 33 step pulses spaced 4 cycles apart → disp_addr walks 1..31,0,1; wrap pulses once, in the cycle rd_addr becomes 0; each disp_data matches the MIF word.
- TICK_CYCLES=4, run=1 → disp_addr increments every 6 cycles; a step pulse injected mid-run changes nothing.
- step pulse during ISSUE → ignored; the address advances only once.
- With RAM_SCAN_WRITE_REFRESH_EN, in HOLD at address 4, write 0xF to address 4 → disp_data=0xF within 4 edges and disp_addr stays 4. Without the macro → disp_data is unchanged.
- reset asserted during CAPTURE → all outputs are 0 the next cycle, then the address-0 pair is captured again.

Source files
------------

// File: rtl/ram_scan_reader_pkg.sv
// Shared types and default geometry for the 32x4 RAM read path (package ram_scan_pkg).
package ram_scan_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 4;

    typedef enum logic [1:0] {
        ISSUE,
        CAPTURE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/ram_scan_reader_if.sv
// RAM read port, mirrored write port, board controls and display pair seen by ram_scan_reader.
interface ram_scan_reader_if
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);

    logic              run;
    logic              step;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wrap;

    modport master (
        input  run, step, wr_en, wr_addr, rd_q,
        output rd_addr, disp_addr, disp_data, disp_valid, wrap
    );

    modport slave (
        output run, step, wr_en, wr_addr, rd_q,
        input  rd_addr, disp_addr, disp_data, disp_valid, wrap
    );

endinterface

// File: rtl/ram_scan_reader_tick_gen.sv
// Auto-advance prescaler: tick is high in the cycle the count reaches TICK_CYCLES-1 while enabled.
module tick_gen #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side sequencer for the dual-port RAM; absorbs read latency and presents a coherent display pair.
// Optional macro RAM_SCAN_WRITE_REFRESH_EN: re-read the displayed address after a colliding write.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int DATA_W      = RAM_DATA_W,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    ram_scan_reader_if.master bus
);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic              wrap_q, wrap_d;
    logic              tick;
    logic              advance;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    ((state_q == HOLD) && bus.run),
        .tick  (tick)
    );

    assign advance = (state_q == HOLD) && (bus.run ? tick : bus.step);

`ifdef RAM_SCAN_WRITE_REFRESH_EN
    logic refresh_q, refresh_d;

    always_comb begin
        refresh_d = refresh_q;
        if (state_q == HOLD) begin
            refresh_d = 1'b0;
        end
        // A write landing on the current address always leaves a re-read owed.
        if (bus.wr_en && (bus.wr_addr == rd_addr_q)) begin
            refresh_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= 1'b0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    logic refresh_q;
    assign refresh_q = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wrap_d       = 1'b0;
        unique case (state_q)
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                disp_addr_d  = rd_addr_q;
                disp_data_d  = bus.rd_q;
                disp_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (advance) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    wrap_d    = (rd_addr_q == '1);
                    state_d   = ISSUE;
                end else if (refresh_q) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ISSUE;
            rd_addr_q    <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bus.rd_addr    = rd_addr_q;
    assign bus.disp_addr  = disp_addr_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.wrap       = wrap_q;

endmodule
